// File: rtl/cascaded_decade_downcounter.sv
// cascaded_decade_downcounter
// N-digit BCD down-counter built from cascaded decade stages, with parallel
// BCD load (digits above 9 clamp to 9), a borrow-in/borrow-out chain for
// cascading instances and a registered one-cycle terminal-count pulse.
// Optional build macro HALT_AT_ZERO_EN: saturate at zero instead of wrapping,
// suppress borrow-out, and emit tc only once per load.
module cascaded_decade_downcounter #(
  parameter int DIGITS = 2
) (
  input  logic                  c,
  input  logic                  r,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   ld_val,
  input  logic                  en,
  input  logic                  bi,
  output logic [4*DIGITS-1:0]   q,
  output logic                  bo,
  output logic                  zero,
  output logic                  tc
);

  localparam int W = 4 * DIGITS;

  // Clamp a load nibble into the legal BCD range.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    logic [3:0] res;
    if (d > 4'd9) begin
      res = 4'd9;
    end else begin
      res = d;
    end
    return res;
  endfunction

  // One decade step downwards, 0 borrows round to 9.
  function automatic logic [3:0] dec_bcd(input logic [3:0] d);
    logic [3:0] res;
    if (d == 4'd0) begin
      res = 4'd9;
    end else begin
      res = d - 4'd1;
    end
    return res;
  endfunction

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         tc_q;
  logic         tc_d;
  logic         zero_s;
  logic         dec_s;
  logic         term_s;
  logic         step_s;
`ifdef HALT_AT_ZERO_EN
  logic         armed_q;
  logic         armed_d;
`endif

  // Status terms: all-zero detect, count qualifier and terminal condition.
  always_comb begin
    zero_s = (cnt_q == {W{1'b0}});
    dec_s  = en & bi & ~ld;
    term_s = dec_s & zero_s;
`ifdef HALT_AT_ZERO_EN
    // Saturating: no movement once the count has reached zero.
    step_s = dec_s & ~zero_s;
`else
    step_s = dec_s;
`endif
  end

  // Next count: load with clamp, else ripple-borrow decrement, else hold.
  always_comb begin : next_count
    logic chain;
    cnt_d = cnt_q;
    chain = 1'b1;
    if (ld) begin
      for (int k = 0; k < DIGITS; k++) begin
        cnt_d[4*k +: 4] = clamp_bcd(ld_val[4*k +: 4]);
      end
    end else if (step_s) begin
      // A digit moves only while every less-significant digit is zero.
      for (int k = 0; k < DIGITS; k++) begin
        if (chain) begin
          cnt_d[4*k +: 4] = dec_bcd(cnt_q[4*k +: 4]);
        end else begin
          cnt_d[4*k +: 4] = cnt_q[4*k +: 4];
        end
        chain = chain & (cnt_q[4*k +: 4] == 4'd0);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Terminal-count pulse (and, when saturating, its one-shot arming flag).
  always_comb begin
`ifdef HALT_AT_ZERO_EN
    tc_d = term_s & armed_q;
    if (ld) begin
      armed_d = 1'b1;
    end else if (term_s) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end
`else
    tc_d = term_s;
`endif
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      cnt_q   <= {W{1'b0}};
      tc_q    <= 1'b0;
`ifdef HALT_AT_ZERO_EN
      armed_q <= 1'b1;
`endif
    end else begin
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
`ifdef HALT_AT_ZERO_EN
      armed_q <= armed_d;
`endif
    end
  end

  assign q    = cnt_q;
  assign zero = zero_s;
  assign tc   = tc_q;
`ifdef HALT_AT_ZERO_EN
  assign bo   = 1'b0;
`else
  assign bo   = en & bi & zero_s;
`endif

endmodule

// File: tb/tb_cascaded_decade_downcounter.sv
// Directed bench for cascaded_decade_downcounter (DIGITS=2). u_lo is the main
// instance; u_hi is cascaded on u_lo's borrow-out for the chain vectors.
module tb_cascaded_decade_downcounter;

  logic       c;
  logic       r;
  logic       ld;
  logic [7:0] lo_ld_val;
  logic [7:0] hi_ld_val;
  logic       en;
  logic       bi;
  logic [7:0] lo_q;
  logic [7:0] hi_q;
  logic       lo_bo;
  logic       hi_bo;
  logic       lo_zero;
  logic       hi_zero;
  logic       lo_tc;
  logic       hi_tc;

  int n_vec;
  int n_bad;

  cascaded_decade_downcounter #(.DIGITS(2)) u_lo (
    .c(c), .r(r), .ld(ld), .ld_val(lo_ld_val), .en(en), .bi(bi),
    .q(lo_q), .bo(lo_bo), .zero(lo_zero), .tc(lo_tc)
  );

  cascaded_decade_downcounter #(.DIGITS(2)) u_hi (
    .c(c), .r(r), .ld(ld), .ld_val(hi_ld_val), .en(en), .bi(lo_bo),
    .q(hi_q), .bo(hi_bo), .zero(hi_zero), .tc(hi_tc)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge c);
    #1;
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    r         = 1'b0;
    ld        = 1'b0;
    lo_ld_val = 8'h00;
    hi_ld_val = 8'h00;
    en        = 1'b1;
    bi        = 1'b1;

    // 1. reset state
    #12;
    check_val("rst_q", {24'h0, lo_q}, 32'h00);
    check_val("rst_zero", {31'h0, lo_zero}, 32'h1);
    check_val("rst_tc", {31'h0, lo_tc}, 32'h0);
`ifdef HALT_AT_ZERO_EN
    check_val("rst_bo", {31'h0, lo_bo}, 32'h0);
`else
    check_val("rst_bo", {31'h0, lo_bo}, 32'h1);
`endif
    en = 1'b0;
    #1;
    check_val("rst_bo_en0", {31'h0, lo_bo}, 32'h0);
    r = 1'b1;

    // load 0x42
    ld = 1'b1; lo_ld_val = 8'h42;
    step();
    check_val("load_42", {24'h0, lo_q}, 32'h42);
    check_val("load_42_zero", {31'h0, lo_zero}, 32'h0);

    // clamp of upper digit: 0xA5 -> 0x95
    lo_ld_val = 8'hA5;
    step();
    check_val("clamp_a5", {24'h0, lo_q}, 32'h95);

    // 2. decade borrow
    lo_ld_val = 8'h10;
    step();
    check_val("load_10", {24'h0, lo_q}, 32'h10);
    ld = 1'b0; en = 1'b1; bi = 1'b1;
    step();
    check_val("borrow_09", {24'h0, lo_q}, 32'h09);
    for (int i = 0; i < 9; i++) step();
    check_val("count_00", {24'h0, lo_q}, 32'h00);
    check_val("count_00_zero", {31'h0, lo_zero}, 32'h1);
    check_val("count_00_tc", {31'h0, lo_tc}, 32'h0);

    // 3. wrap and terminal count
`ifdef HALT_AT_ZERO_EN
    check_val("pre_wrap_bo", {31'h0, lo_bo}, 32'h0);
    step();
    check_val("halt_q", {24'h0, lo_q}, 32'h00);
    check_val("halt_tc", {31'h0, lo_tc}, 32'h1);
    step();
    check_val("halt_q2", {24'h0, lo_q}, 32'h00);
    check_val("halt_tc2", {31'h0, lo_tc}, 32'h0);
    en = 1'b0;
`else
    check_val("pre_wrap_bo", {31'h0, lo_bo}, 32'h1);
    step();
    check_val("wrap_q", {24'h0, lo_q}, 32'h99);
    check_val("wrap_tc", {31'h0, lo_tc}, 32'h1);
    en = 1'b0;
    step();
    check_val("wrap_q_hold", {24'h0, lo_q}, 32'h99);
    check_val("wrap_tc_off", {31'h0, lo_tc}, 32'h0);
`endif

    // 4. priority and clamp
    ld = 1'b1; en = 1'b1; lo_ld_val = 8'h3F;
    step();
    check_val("ld_prio_q", {24'h0, lo_q}, 32'h39);
    check_val("ld_prio_tc", {31'h0, lo_tc}, 32'h0);
    ld = 1'b0; bi = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_val("bi0_hold", {24'h0, lo_q}, 32'h39);
    check_val("bi0_bo", {31'h0, lo_bo}, 32'h0);

    // 5. cascade
    bi = 1'b1; en = 1'b0; ld = 1'b1;
    lo_ld_val = 8'h00; hi_ld_val = 8'h05;
    step();
    check_val("casc_ld_lo", {24'h0, lo_q}, 32'h00);
    check_val("casc_ld_hi", {24'h0, hi_q}, 32'h05);
    ld = 1'b0; en = 1'b1;
    #1;
`ifdef HALT_AT_ZERO_EN
    check_val("casc_bo", {31'h0, lo_bo}, 32'h0);
    step();
    check_val("casc_lo", {24'h0, lo_q}, 32'h00);
    check_val("casc_hi", {24'h0, hi_q}, 32'h05);
`else
    check_val("casc_bo", {31'h0, lo_bo}, 32'h1);
    step();
    check_val("casc_lo", {24'h0, lo_q}, 32'h99);
    check_val("casc_hi", {24'h0, hi_q}, 32'h04);
`endif

    // 6. asynchronous reset mid-count
    en = 1'b0; ld = 1'b1; lo_ld_val = 8'h57;
    step();
    ld = 1'b0; en = 1'b1;
    step();
    check_val("cnt_56", {24'h0, lo_q}, 32'h56);
    #2 r = 1'b0;
    #1;
    check_val("async_q", {24'h0, lo_q}, 32'h00);
    check_val("async_tc", {31'h0, lo_tc}, 32'h0);
    #2 r = 1'b1;

    // reset while tc is high
    en = 1'b0; ld = 1'b1; lo_ld_val = 8'h01;
    step();
    ld = 1'b0; en = 1'b1;
    step();
    check_val("cnt_00b", {24'h0, lo_q}, 32'h00);
    step();
    check_val("tc_before_rst", {31'h0, lo_tc}, 32'h1);
    #2 r = 1'b0;
    #1;
    check_val("async_tc_clr", {31'h0, lo_tc}, 32'h0);
    check_val("async_q_clr", {24'h0, lo_q}, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cascaded_decade_downcounter.md
Name: cascaded_decade_downcounter

Overview:
N-digit BCD down-counter built from cascaded decade stages. It is the count-down counterpart of the team's decade up-counter chain and is intended for countdown timers and delay generation. It supports parallel BCD load, a borrow-in/borrow-out chain for cascading multiple instances, and a registered terminal-count pulse.

Parameters:
DIGITS, 2, number of BCD decades (1..8); digit 0 is least significant.

Ports:
c  input  1  clock; all state changes on posedge.
r  input  1  asynchronous reset, active-low (0 = reset).
ld  input  1  synchronous parallel load strobe.
ld_val  input  4*DIGITS  BCD load value; digit k occupies bits [4k+3:4k].
en  input  1  count enable.
bi  input  1  borrow-in from the less-significant instance; tie to 1 when standalone.
q  output  4*DIGITS  current BCD count, registered.
bo  output  1  borrow-out to the more-significant instance; combinational.
zero  output  1  high when every digit of q is 0; combinational from q.
tc  output  1  registered terminal-count pulse.

Behaviour:
- Reset (r=0, asynchronous, independent of c): q = 0, tc = 0. Consequently zero = 1 and bo = en & bi during reset.
- Leaving reset is synchronous: the first state change occurs on the first posedge c with r=1.
- Per-edge priority: reset > ld > count > hold.
- Load (ld=1): q <= ld_val, applied digit by digit. Any digit value A–F is clamped to 9. tc <= 0. Load wins over a simultaneous count, and no decrement occurs on that edge.
- Count condition: dec = en & bi & ~ld.
- Decrement digit-wise:
  - Digit 0 decrements when dec = 1.
  - Digit k>0 decrements when dec = 1 and digits 0..k-1 are all 0.
  - Any decrementing digit at 0 becomes 9; otherwise it becomes value-1.
- Wrap: all-zero with dec = 1 gives q <= all 9s (e.g. 00 → 99 for DIGITS=2).
- bo = en & bi & zero. bo is combinational, so a cascade of instances decrements in a single cycle.
- tc <= 1 for exactly one cycle on the edge where dec = 1 and zero = 1; otherwise tc <= 0. tc therefore rises in the cycle after the wrap edge.
- Hold: with dec = 0 and ld = 0, q is unchanged and tc <= 0.
- Reset mid-count immediately forces q = 0 and tc = 0; any pending count is lost.
- Latency: q updates one edge after ld or dec; zero follows q combinationally; tc is one cycle after the terminal edge.

Optional Feature:
Macro HALT_AT_ZERO_EN.
- Defined: the counter saturates at zero instead of wrapping.
  - dec with zero = 1 leaves q = 0.
  - bo is forced to 0, so upper instances do not decrement.
  - tc still pulses on the first edge where dec = 1 and zero = 1. Further counts while at zero produce no additional tc pulse.
  - A new ld re-arms both counting and tc.
- Undefined: wrap behaviour exactly as in Behaviour above.

Test Plan:
1. Reset and load (DIGITS=2): hold r=0 → q=00, zero=1, tc=0. Release r, pulse ld with ld_val=0x42 → next edge q=0x42.
2. Decade borrow: load 0x10, en=1, bi=1 for 1 edge → q=0x09. Then 9 more edges → q=0x00 and zero=1.
3. Wrap and tc: from q=0x00, en=1 for 1 edge → q=0x99 and bo=1 during the cycle before the edge. tc=1 for exactly the next cycle, then 0. (With HALT_AT_ZERO_EN: q stays 0x00, bo=0, tc pulses once, and a second count edge gives no tc.)
4. Priority and clamp: ld=1 together with en=1, ld_val=0x3F → q=0x39, no decrement. en=1 with bi=0 for 5 edges → q unchanged.
5. Cascade: two instances, lower.bo driving upper.bi, shared en=1. Load lower=0x00 and upper=0x05; 1 edge → lower=0x99, upper=0x04.
6. Async reset mid-count: count from 0x57 and assert r=0 between edges → q=0x00 and tc=0 immediately, without waiting for c.
